aes_key_sched_iter: RTL
=======================

AES_KEY_SCHED_ITER -- requirements
Module: aes_key_sched_iter

Interface
REQ-001 Parameter KEY_BITS, default 128, key length in bits; legal values 128 and 256; any other value SHALL fail elaboration.
REQ-002 Derived constant NR SHALL be 10 for KEY_BITS=128 and 14 for KEY_BITS=256.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 key_valid  input  1  key_in is valid this cycle.
REQ-006 key_ready  output  1  block accepts a new key this cycle.
REQ-007 key_in  input  KEY_BITS  cipher key, big-endian word order (w0 in MSBs).
REQ-008 rk_valid  output  1  rk_out holds a valid round key.
REQ-009 rk_ready  input  1  consumer accepts rk_out this cycle.
REQ-010 rk_out  output  128  round key, words {w4i, w4i+1, w4i+2, w4i+3}.
REQ-011 rk_index  output  4  round number (0..NR) of rk_out.
REQ-012 rk_last  output  1  high with rk_valid when rk_index == NR.

Function
REQ-013 Key handshake SHALL occur in a cycle where key_valid && key_ready; round-key handshake SHALL occur in a cycle where rk_valid && rk_ready.
REQ-014 FSM states SHALL be IDLE, SUB and EMIT.
REQ-015 key_ready SHALL be 1 only in IDLE; key_valid outside IDLE SHALL be ignored.
REQ-016 IDLE -> EMIT on key handshake; rk_out = key_in[KEY_BITS-1 -: 128] and rk_index = 0 in the next cycle.
REQ-017 EMIT with round-key handshake and rk_index < NR -> SUB; with rk_index == NR -> IDLE.
REQ-018 SUB SHALL last exactly 1 cycle, covering the registered SubWord latency of the existing S4 substitution module, then -> EMIT with rk_index incremented by 1.
REQ-019 rk_valid SHALL be 1 only in EMIT; the minimum spacing between consecutive round keys SHALL be 2 cycles; total minimum latency from key handshake to rk_last SHALL be 2*NR+1 cycles.
REQ-020 While rk_valid && !rk_ready, rk_out, rk_index and rk_last SHALL remain stable.
REQ-021 KEY_BITS=128: round i (1..NR) SHALL be computed as t = SubWord(RotWord(w4i-1)) ^ {rcon(i),24'h0}, then w4i = w4i-4 ^ t with each later word chained as w_j = w_j-4 ^ w_j-1.
REQ-022 KEY_BITS=256: round 1 SHALL equal key_in[127:0] and SHALL use no substitution, although it still passes through SUB timing.
REQ-023 KEY_BITS=256, even i >= 2: t = SubWord(RotWord(w4i-1)) ^ {rcon(i/2),24'h0}.
REQ-024 KEY_BITS=256, odd i >= 3: t = SubWord(w4i-1), with no rotate and no rcon.
REQ-025 KEY_BITS=256: each word SHALL be w_j = w_j-8 ^ (t for the first word, else w_j-1), using the two previous round keys held internally.
REQ-026 rcon SHALL start at 8'h01 and advance by GF(2^8) xtime (x^8+x^4+x^3+x+1), giving 01,02,04,08,10,20,40,80,1b,36.
REQ-027 The rcon register SHALL be reloaded to 8'h01 on every key handshake.
REQ-028 All XOR arithmetic SHALL be bitwise at 32-bit word width; no carries.

Reset
REQ-029 While rst_n = 0: state IDLE, key_ready = 1 after release, rk_valid = 0, rk_last = 0, rk_index = 0, rk_out = 0, rcon = 8'h01, all internal key registers = 0.
REQ-030 Reset asserted mid-schedule SHALL immediately drop rk_valid and discard the schedule in progress; the first cycle after release SHALL accept a new key.

Verification
REQ-031 KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> rk_index 1 = a0fafe1788542cb123a339392a6c7605; rk_index 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last = 1, 21 cycles after the key handshake.
REQ-032 KEY_BITS=128, key 000102030405060708090a0b0c0d0e0f -> rk_index 10 = 13111d7fe3944a17f307a78b4d2b30c5.
REQ-033 KEY_BITS=256, key 000102...1e1f -> rk_index 1 = 101112131415161718191a1b1c1d1e1f; rk_index 2 = a573c29fa176c498a97fce93a572c09c; rk_index 14 = 24fc79ccbf0979e9371ac23c6d68de36 with rk_last = 1.
REQ-034 Random rk_ready backpressure with 0-5 stall cycles -> same round-key sequence, rk_out stable during every stall, exactly NR+1 handshakes.
REQ-035 key_valid held high throughout a schedule -> second key accepted only after the rk_last handshake, with its rk_index 0 equal to the second key.
REQ-036 rst_n pulsed low during round 5 -> rk_valid = 0 immediately; a new key after release produces correct results from round 0.

Source files
------------

// File: rtl/aes_key_sched_iter.sv
// Iterative AES key schedule: emits round keys 0..NR one per handshake.
// A single registered SubWord stage sits between consecutive round keys,
// so each new key costs one SUB cycle followed by one EMIT cycle.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// valid never depends on ready, and while valid && !ready every payload
// output (rk_out, rk_index, rk_last) holds its value.
module aes_key_sched_iter #(
   parameter int KEY_BITS = 128
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                key_valid,
   output logic                key_ready,
   input  logic [KEY_BITS-1:0] key_in,
   output logic                rk_valid,
   input  logic                rk_ready,
   output logic [127:0]        rk_out,
   output logic [3:0]          rk_index,
   output logic                rk_last,
   output logic [1:0]          dbg_state
);

   localparam int         NR     = (KEY_BITS == 256) ? 14 : 10;
   localparam logic [3:0] NR_IDX = 4'(NR);

   generate
      if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
         $error("aes_key_sched_iter: KEY_BITS must be 128 or 256");
      end
   endgenerate

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      EMIT = 2'd2
   } state_e;

   state_e       state_q, state_d;
   logic [127:0] rk_q, rk_d;       // current round key {w4i .. w4i+3}
   logic [127:0] prev_q, prev_d;   // previous round key (256-bit schedule only)
   logic [3:0]   idx_q, idx_d;
   logic [7:0]   rcon_q, rcon_d;
   logic [31:0]  sub_q, sub_d;     // registered SubWord result

   logic         key_hs;
   logic         rk_hs;
   logic [3:0]   idx_next;
   logic         rotate;
   logic [31:0]  sel_word;
   logic [31:0]  t_word;
   logic [127:0] base;
   logic [31:0]  nw0, nw1, nw2, nw3;
   logic         rcon_adv;
   logic [7:0]   rcon_xtime;

   assign key_hs = key_valid && key_ready;
   assign rk_hs  = rk_valid && rk_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (key_hs) state_d = EMIT;
         SUB:     state_d = EMIT;
         EMIT:    if (rk_hs) state_d = (idx_q == NR_IDX) ? IDLE : SUB;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from state and the held round key
   always_comb begin
      key_ready = (state_q == IDLE);
      rk_valid  = (state_q == EMIT);
      rk_last   = (state_q == EMIT) && (idx_q == NR_IDX);
      rk_out    = rk_q;
      rk_index  = idx_q;
      dbg_state = state_q;
   end

   // Round arithmetic: idx_next is the round being built during EMIT/SUB
   always_comb begin
      idx_next   = idx_q + 4'd1;
      // 256-bit odd rounds substitute without rotation or rcon
      rotate     = (KEY_BITS == 128) || !idx_next[0];
      sel_word   = rotate ? {rk_q[23:0], rk_q[31:24]} : rk_q[31:0];
      rcon_adv   = (KEY_BITS == 128) || !idx_next[0];
      t_word     = rcon_adv ? (sub_q ^ {rcon_q, 24'h0}) : sub_q;
      base       = (KEY_BITS == 256) ? prev_q : rk_q;
      nw0        = base[127:96] ^ t_word;
      nw1        = base[95:64]  ^ nw0;
      nw2        = base[63:32]  ^ nw1;
      nw3        = base[31:0]   ^ nw2;
      rcon_xtime = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
   end

   // Next values of the key registers
   always_comb begin
      rk_d   = rk_q;
      prev_d = prev_q;
      idx_d  = idx_q;
      rcon_d = rcon_q;
      sub_d  = sub_q;
      case (state_q)
         IDLE: begin
            if (key_hs) begin
               rk_d   = key_in[KEY_BITS-1 -: 128];
               prev_d = key_in[127:0];
               idx_d  = 4'd0;
               rcon_d = 8'h01;
            end
         end
         EMIT: begin
            // rk_q is stable in EMIT, so the lookup is ready for SUB
            sub_d = {SBOX[sel_word[31:24]], SBOX[sel_word[23:16]],
                     SBOX[sel_word[15:8]],  SBOX[sel_word[7:0]]};
         end
         SUB: begin
            // 256-bit round 1 is simply the lower key half swapped in
            if (KEY_BITS == 256 && idx_q == 4'd0) begin
               rk_d = prev_q;
            end else begin
               rk_d = {nw0, nw1, nw2, nw3};
            end
            prev_d = rk_q;
            idx_d  = idx_next;
            if (rcon_adv) rcon_d = rcon_xtime;
         end
         default: ;
      endcase
   end

   // Key register bank
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rk_q   <= '0;
         prev_q <= '0;
         idx_q  <= '0;
         rcon_q <= 8'h01;
         sub_q  <= '0;
      end else begin
         rk_q   <= rk_d;
         prev_q <= prev_d;
         idx_q  <= idx_d;
         rcon_q <= rcon_d;
         sub_q  <= sub_d;
      end
   end

endmodule
